// File: rtl/arb_pkg.sv
// Shared definitions for the request arbiters: requester count, index width
// and the two-state arbitration FSM encoding.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/grant_decoder2to4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when EN is low.
module grant_decoder2to4
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] A,
  input  logic             EN,
  output logic [N_REQ-1:0] D
);

  // One-hot decode of the index, gated by the enable
  always_comb begin
    D = '0;
    if (EN) D[A] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter. A registered 2-bit owner index is
// decoded to one-hot grant lines. Every tenure ends through IDLE, so there is
// always at least one dead cycle between owners. Optional hold timeout forces
// release after MAX_HOLD cycles (0 disables it).
// The owner's release strobe is named release_pulse because "release" is a
// reserved word.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             release_pulse,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam bit TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    TIMEOUT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              owner_drop;
  logic              hold_hit;

  // First set request bit searching ptr, ptr+1, ... with modulo-4 wrap.
  // Offsets are visited highest first so the lowest offset is the last write.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = p;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = p + IDX_W'(N_REQ - 1 - k);
      if (r[cand]) pick = cand;
    end
    return pick;
  endfunction

  // Tenure-ending conditions while BUSY
  always_comb begin
    owner_drop = release_pulse | ~req[grant_idx];
    hold_hit   = TIMEOUT_EN && (hold_cnt == HOLD_LAST);
  end

  // Arbitration FSM, owner register, rotating pointer and hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else if (state == IDLE) begin
      timeout <= 1'b0;
      if (|req) begin
        grant_idx   <= rr_pick(req, ptr);
        grant_valid <= 1'b1;
        hold_cnt    <= '0;
        state       <= BUSY;
      end
    end else begin
      if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
      if (owner_drop || hold_hit) begin
        state       <= IDLE;
        grant_valid <= 1'b0;
        ptr         <= grant_idx + 1'b1;
        timeout     <= hold_hit & ~owner_drop;
      end else begin
        timeout <= 1'b0;
      end
    end
  end

  grant_decoder2to4 u_dec (
    .A  (grant_idx),
    .EN (grant_valid),
    .D  (grant)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (MAX_HOLD = 0, 5, 3) share one
// stimulus stream and are each compared every cycle against a behavioural
// model of the arbitration rules, plus directed scenario checks.
`timescale 1ns/1ps
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       rls;

  logic [3:0] g   [3];
  logic [1:0] gi  [3];
  logic       gv  [3];
  logic       tmo [3];

  int total = 0;
  int bad   = 0;

  // Behavioural model state per instance
  int mh      [3] = '{0, 5, 3};
  int m_idx   [3];
  int m_ptr   [3];
  int m_hold  [3];
  bit m_valid [3];
  bit m_to    [3];

  rr_arbiter4 #(.MAX_HOLD(0), .HOLD_W(8)) u_arb0 (
    .clk(clk), .rst(rst), .req(req), .release_pulse(rls),
    .grant(g[0]), .grant_idx(gi[0]), .grant_valid(gv[0]), .timeout(tmo[0]));

  rr_arbiter4 #(.MAX_HOLD(5), .HOLD_W(8)) u_arb1 (
    .clk(clk), .rst(rst), .req(req), .release_pulse(rls),
    .grant(g[1]), .grant_idx(gi[1]), .grant_valid(gv[1]), .timeout(tmo[1]));

  rr_arbiter4 #(.MAX_HOLD(3), .HOLD_W(8)) u_arb2 (
    .clk(clk), .rst(rst), .req(req), .release_pulse(rls),
    .grant(g[2]), .grant_idx(gi[2]), .grant_valid(gv[2]), .timeout(tmo[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      m_idx[n] = 0; m_ptr[n] = 0; m_hold[n] = 0;
      m_valid[n] = 1'b0; m_to[n] = 1'b0;
    end
  endtask

  // One clock edge of the arbitration rules, using the sampled req/release
  task automatic model_step();
    bit a, b, c;
    if (rst) begin
      model_reset();
      return;
    end
    for (int n = 0; n < 3; n++) begin
      if (!m_valid[n]) begin
        m_to[n] = 1'b0;
        if (req != 4'b0000) begin
          for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr[n] + k) % 4;
            if (req[i]) begin
              m_idx[n] = i; m_valid[n] = 1'b1; m_hold[n] = 0;
              break;
            end
          end
        end
      end else begin
        a = rls;
        b = !req[m_idx[n]];
        c = (mh[n] != 0) && (m_hold[n] == mh[n] - 1);
        if (m_hold[n] < 255) m_hold[n]++;
        if (a || b || c) begin
          m_valid[n] = 1'b0;
          m_ptr[n]   = (m_idx[n] + 1) % 4;
          m_to[n]    = c && !a && !b;
        end else begin
          m_to[n] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    for (int n = 0; n < 3; n++) begin
      eg = m_valid[n] ? (4'b0001 << m_idx[n]) : 4'b0000;
      check($sformatf("u%0d.grant", n), g[n], eg);
      check($sformatf("u%0d.grant_idx", n), gi[n], m_idx[n]);
      check($sformatf("u%0d.grant_valid", n), gv[n], m_valid[n]);
      check($sformatf("u%0d.timeout", n), tmo[n], m_to[n]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int guard;
    rst = 1'b1; req = 4'b0000; rls = 1'b0;
    model_reset();
    #1;
    check("reset.grant", g[0], 4'b0000);
    check("reset.grant_valid", gv[0], 1'b0);
    tick();
    rst = 1'b0;

    // Round-robin: all request, release after every 2 BUSY cycles
    req = 4'b1111;
    for (int o = 0; o < 4; o++) begin
      tick();
      check($sformatf("rr.own%0d.c1", o), g[0], 4'b0001 << o);
      tick();
      check($sformatf("rr.own%0d.c2", o), g[0], 4'b0001 << o);
      rls = 1'b1;
      tick();
      rls = 1'b0;
      check($sformatf("rr.gap%0d", o), g[0], 4'b0000);
    end
    tick();
    check("rr.wrap", g[0], 4'b0001);
    req = 4'b0000;
    tick();

    // Owner withdrawal: ptr moves to 2, so master 3 wins over master 0
    do_reset();
    req = 4'b0010;
    tick();
    check("wd.own1", g[0], 4'b0010);
    req = 4'b1001;
    tick();
    check("wd.gap", g[0], 4'b0000);
    tick();
    check("wd.own3", g[0], 4'b1000);
    req = 4'b0000;
    tick();

    // Asynchronous reset in the middle of a tenure
    do_reset();
    req = 4'b0100;
    tick();
    check("ar.own2", g[0], 4'b0100);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("ar.grant_now", g[0], 4'b0000);
    check("ar.valid_now", gv[0], 1'b0);
    tick();
    rst = 1'b0;
    req = 4'b0001;
    tick();
    check("ar.regrant", g[0], 4'b0001);

    // Timeout on the MAX_HOLD=5 instance
    req = 4'b0000;
    do_reset();
    req = 4'b0001;
    tick();
    cnt = 0;
    guard = 0;
    while (gv[1] && guard < 12) begin
      cnt++;
      guard++;
      tick();
    end
    check("to.hold_cycles", cnt, 5);
    check("to.pulse", tmo[1], 1'b1);
    check("to.gap", g[1], 4'b0000);
    tick();
    check("to.regrant", g[1], 4'b0001);
    check("to.pulse_gone", tmo[1], 1'b0);

    // Release coinciding with timeout on the MAX_HOLD=3 instance
    req = 4'b0000;
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    tick();
    check("col.busy3", gv[2], 1'b1);
    rls = 1'b1;
    tick();
    rls = 1'b0;
    check("col.exit", gv[2], 1'b0);
    check("col.no_timeout", tmo[2], 1'b0);

    // Idle stability with stray release pulses
    req = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      rls = 1'($urandom % 2);
      tick();
      for (int n = 0; n < 3; n++) begin
        check($sformatf("idle.u%0d.grant", n), g[n], 4'b0000);
        check($sformatf("idle.u%0d.valid", n), gv[n], 1'b0);
        check($sformatf("idle.u%0d.timeout", n), tmo[n], 1'b0);
      end
    end
    rls = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 4 == 0) req = 4'($urandom);
      rls = ($urandom % 6 == 0);
      if ($urandom % 300 == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
